// File: rtl/bonsai_refill_pkg.sv
// Shared types and constants for the leaf refill scheduler.
package bonsai_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One memory line is 512 b = 64 B and carries four 128 b records.
    localparam int LINE_BYTES    = 64;
    localparam int RECS_PER_LINE = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping.
// Purely combinational.
module rr_arbiter #(
    parameter int N  = 128,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    output logic [LW-1:0] gnt,
    output logic          found
);

    logic [LW:0] idx;

    // Scan N slots starting at ptr; the extra index bit absorbs ptr+i before the wrap.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (LW+1)'(i);
            if (idx >= (LW+1)'(N))
                idx = idx - (LW+1)'(N);
            if (!found && req[idx[LW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[LW-1:0];
            end
        end
    end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Leaf refill scheduler: issues 64 B line reads round-robin across the leaf
// buffers of the merger tree, bounded by per-leaf credits and a global cap on
// outstanding reads. Optional REFILL_STATS_EN adds stall/starve counters.
module leaf_refill_scheduler
    import bonsai_refill_pkg::*;
#(
    parameter int LEAF_CNT        = 128,
    parameter int ADDR_WIDTH      = 32,
    parameter int LINES_WIDTH     = 16,
    parameter int BUF_DEPTH       = 32,
    parameter int OUTSTANDING_MAX = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_we,
    input  logic [$clog2(LEAF_CNT)-1:0] i_cfg_leaf,
    input  logic [ADDR_WIDTH-1:0]       i_cfg_addr,
    input  logic [LINES_WIDTH-1:0]      i_cfg_lines,
    input  logic                        i_start,
    output logic                        o_req_valid,
    input  logic                        i_req_ready,
    output logic [ADDR_WIDTH-1:0]       o_req_addr,
    output logic [$clog2(LEAF_CNT)-1:0] o_req_leaf,
    input  logic                        i_resp_valid,
    input  logic [LEAF_CNT-1:0]         i_leaf_deq,
    output logic                        o_busy,
    output logic                        o_done
`ifdef REFILL_STATS_EN
    ,
    output logic [31:0]                 o_stall_cycles,
    output logic [31:0]                 o_starve_cycles
`endif
);

    localparam int LW = $clog2(LEAF_CNT);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = $clog2(OUTSTANDING_MAX + 1);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]  leaf_addr   [LEAF_CNT];
    logic [LINES_WIDTH-1:0] leaf_lines  [LEAF_CNT];
    logic [CW-1:0]          leaf_credit [LEAF_CNT];
    logic [ADDR_WIDTH-1:0]  addr_nxt    [LEAF_CNT];
    logic [LINES_WIDTH-1:0] lines_nxt   [LEAF_CNT];
    logic [CW-1:0]          credit_nxt  [LEAF_CNT];

    logic [OW-1:0]       outstanding, outstanding_nxt;
    logic [LW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [LEAF_CNT-1:0] elig_nxt;
    logic [LEAF_CNT-1:0] arb_req;
    logic [LW-1:0]       gnt;
    logic                gnt_found;
    logic                hs;
    logic                all_drained;

    assign hs = o_req_valid & i_req_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus busy/done. RUN ends only once nothing is left to issue
    // and no request is sitting on the bus; done fires from DRAIN when empty.
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE:  if (i_start) state_nxt = RUN;
            RUN: begin
                o_busy = 1'b1;
                if (all_drained && !o_req_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (outstanding == '0) begin
                    o_done    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-leaf next values: config (IDLE only), issue bookkeeping and credit
    // return. Eligibility is judged on these post-edge values so a leaf that
    // is being issued right now is not granted against stale counters.
    always_comb begin
        for (int l = 0; l < LEAF_CNT; l++) begin
            addr_nxt[l]   = leaf_addr[l];
            lines_nxt[l]  = leaf_lines[l];
            credit_nxt[l] = leaf_credit[l];
            if (state == IDLE && i_cfg_we && i_cfg_leaf == LW'(l)) begin
                addr_nxt[l]  = i_cfg_addr;
                lines_nxt[l] = i_cfg_lines;
            end
            if (hs && o_req_leaf == LW'(l)) begin
                addr_nxt[l]  = leaf_addr[l] + ADDR_WIDTH'(LINE_BYTES);
                lines_nxt[l] = leaf_lines[l] - LINES_WIDTH'(1);
                if (!i_leaf_deq[l])
                    credit_nxt[l] = leaf_credit[l] - CW'(1);
            end else if (i_leaf_deq[l] && leaf_credit[l] != CW'(BUF_DEPTH)) begin
                credit_nxt[l] = leaf_credit[l] + CW'(1);
            end
            elig_nxt[l] = (lines_nxt[l] != '0) && (credit_nxt[l] != '0);
        end
    end

    // Global counters: outstanding reads, RR pointer, and the drained flag.
    always_comb begin
        outstanding_nxt = outstanding;
        case ({hs, i_resp_valid})
            2'b10:   outstanding_nxt = outstanding + OW'(1);
            2'b01:   if (outstanding != '0) outstanding_nxt = outstanding - OW'(1);
            default: outstanding_nxt = outstanding;
        endcase
        rr_ptr_nxt = rr_ptr;
        if (hs)
            rr_ptr_nxt = (o_req_leaf == LW'(LEAF_CNT - 1)) ? '0 : o_req_leaf + LW'(1);
        all_drained = 1'b1;
        for (int l = 0; l < LEAF_CNT; l++)
            if (leaf_lines[l] != '0) all_drained = 1'b0;
    end

    assign arb_req = elig_nxt & {LEAF_CNT{outstanding_nxt < OW'(OUTSTANDING_MAX)}};

    rr_arbiter #(.N(LEAF_CNT), .LW(LW)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_nxt),
        .gnt   (gnt),
        .found (gnt_found)
    );

    // Per-leaf state arrays.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int l = 0; l < LEAF_CNT; l++) begin
                leaf_addr[l]   <= '0;
                leaf_lines[l]  <= '0;
                leaf_credit[l] <= CW'(BUF_DEPTH);
            end
        end else begin
            for (int l = 0; l < LEAF_CNT; l++) begin
                leaf_addr[l]   <= addr_nxt[l];
                leaf_lines[l]  <= lines_nxt[l];
                leaf_credit[l] <= credit_nxt[l];
            end
        end
    end

    // Outstanding count and RR pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding <= '0;
            rr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            rr_ptr      <= rr_ptr_nxt;
        end
    end

    // Registered grant; a presented request is frozen until accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_req_valid <= 1'b0;
            o_req_addr  <= '0;
            o_req_leaf  <= '0;
        end else if (!o_req_valid || hs) begin
            o_req_valid <= (state == RUN) && gnt_found;
            if ((state == RUN) && gnt_found) begin
                o_req_addr <= addr_nxt[gnt];
                o_req_leaf <= gnt;
            end
        end
    end

`ifdef REFILL_STATS_EN
    logic any_lines, any_elig;

    // Starvation is judged on current state: work remains but nobody may issue.
    always_comb begin
        any_lines = 1'b0;
        any_elig  = 1'b0;
        for (int l = 0; l < LEAF_CNT; l++) begin
            if (leaf_lines[l] != '0) any_lines = 1'b1;
            if (leaf_lines[l] != '0 && leaf_credit[l] != '0) any_elig = 1'b1;
        end
        if (outstanding >= OW'(OUTSTANDING_MAX)) any_elig = 1'b0;
    end

    // Saturating stall/starve counters, cleared when a run is started.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == IDLE && i_start)) begin
            o_stall_cycles  <= '0;
            o_starve_cycles <= '0;
        end else begin
            if (o_req_valid && !i_req_ready && o_stall_cycles != '1)
                o_stall_cycles <= o_stall_cycles + 32'd1;
            if (state == RUN && any_lines && !any_elig && o_starve_cycles != '1)
                o_starve_cycles <= o_starve_cycles + 32'd1;
        end
    end
`endif

endmodule
